// File: rtl/multiword_add_ctrl_if.sv
//------------------------------------------------------------------------------
// multiword_add_ctrl_if : request/result handshake bundle for multiword_add_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface multiword_add_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  modport master (
    output in_valid, op_a, op_b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

`default_nettype wire

// File: rtl/multiword_add_ctrl.sv
//------------------------------------------------------------------------------
// multiword_add_ctrl : 64-bit add/sub built from one 16-bit slice, 4 cycles/op
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multiword_add_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  multiword_add_ctrl_if.slave   bus_io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic        carry_q, carry_d;
  logic [1:0]  idx_q, idx_d;
  logic [63:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;

  logic [15:0] w_a_word;
  logic [15:0] w_b_word;
  logic [16:0] w_slice;

  // The single shared slice; b_q already holds the effective (possibly inverted) B.
  assign w_a_word = a_q[{idx_q, 4'd0} +: 16];
  assign w_b_word = b_q[{idx_q, 4'd0} +: 16];
  assign w_slice  = {1'b0, w_a_word} + {1'b0, w_b_word} + {16'd0, carry_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 64'd0;
      b_q     <= 64'd0;
      carry_q <= 1'b0;
      idx_q   <= 2'd0;
      sum_q   <= 64'd0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus_io.in_valid) begin
          a_d     = bus_io.op_a;
          b_d     = bus_io.sub ? ~bus_io.op_b : bus_io.op_b;
          carry_d = bus_io.sub ? 1'b1 : bus_io.cin;
          idx_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 4'd0} +: 16] = w_slice[15:0];
        carry_d = w_slice[16];
        if (idx_q == 2'd3) begin
          // idx stays at 3 until the next acceptance reloads it.
          state_d = DONE;
          cout_d  = w_slice[16];
          ovf_d   = (a_q[63] == b_q[63]) && (w_slice[15] != a_q[63]);
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      DONE: begin
        if (bus_io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus_io.in_ready  = (state_q == IDLE);
  assign bus_io.out_valid = (state_q == DONE);
  assign bus_io.busy      = (state_q != IDLE);
  assign bus_io.sum       = sum_q;
  assign bus_io.cout      = cout_q;
  assign bus_io.ovf       = ovf_q;

endmodule

`default_nettype wire
